// File: rtl/eviction_write_buffer_if.sv
// Upstream line port (cache core <-> buffer) and downstream line port (buffer <-> memory).
// The buffer uses the slave view; the cache/memory side uses the master view.
interface eviction_write_buffer_if #(
  parameter int unsigned s_line = 256
) ();
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [s_line-1:0] mem_wdata;
  logic              mem_resp;
  logic [s_line-1:0] mem_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [s_line-1:0] pmem_rdata;

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/eviction_write_buffer.sv
// One-line eviction write buffer: acks write-backs immediately, lets read misses
// bypass the pending write-back, and drains the line after an idle period.
module eviction_write_buffer #(
  parameter int unsigned s_offset    = 5,
  parameter int unsigned s_line      = 256,
  parameter int unsigned drain_delay = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  eviction_write_buffer_if.slave bus
);
  localparam int unsigned tag_w = 32 - s_offset;
  localparam int unsigned cnt_w = $clog2(drain_delay + 1);
  localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_resp  = 2'd1;
  localparam logic [1:0] st_read  = 2'd2;
  localparam logic [1:0] st_drain = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [tag_w-1:0]  tag_q, tag_d;
  logic [s_line-1:0] data_q, data_d;
  logic [s_line-1:0] rdata_q, rdata_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic              mem_resp_q, mem_resp_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [31:0]       pmem_addr_q, pmem_addr_d;

  logic [tag_w-1:0]  req_tag;
  logic              match;
  logic [cnt_w-1:0]  cnt_inc;

  assign req_tag = tag_w'(bus.mem_address >> s_offset);
  assign match   = valid_q & (req_tag == tag_q);
  assign cnt_inc = (cnt_q == cnt_w'(drain_delay)) ? cnt_q : cnt_q + cnt_w'(1);

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    mem_resp_d   = 1'b0;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    pmem_addr_d  = pmem_addr_q;

    case (state_q)
      st_idle: begin
        if (bus.mem_write && !mem_resp_q) begin
          cnt_d = '0;
          if (!valid_q || match) begin
            // Same-line writes simply overwrite the buffered copy.
            valid_d    = 1'b1;
            tag_d      = req_tag;
            data_d     = bus.mem_wdata;
            mem_resp_d = 1'b1;
            state_d    = st_resp;
          end else begin
            pmem_write_d = 1'b1;
            pmem_addr_d  = {tag_q, {s_offset{1'b0}}};
            state_d      = st_drain;
          end
        end else if (bus.mem_read && !mem_resp_q) begin
          cnt_d = '0;
          if (match) begin
            rdata_d    = data_q;
            mem_resp_d = 1'b1;
            state_d    = st_resp;
          end else begin
            pmem_read_d = 1'b1;
            pmem_addr_d = bus.mem_address & line_mask;
            state_d     = st_read;
          end
        end else if (valid_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == cnt_w'(drain_delay)) begin
            pmem_write_d = 1'b1;
            pmem_addr_d  = {tag_q, {s_offset{1'b0}}};
            state_d      = st_drain;
          end
        end
      end
      st_resp: state_d = st_idle;
      st_read: begin
        cnt_d = '0;
        if (bus.pmem_resp) begin
          pmem_read_d = 1'b0;
          state_d     = st_idle;
        end
      end
      st_drain: begin
        if (bus.pmem_resp) begin
          pmem_write_d = 1'b0;
          valid_d      = 1'b0;
          cnt_d        = '0;
          state_d      = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= st_idle;
      valid_q      <= 1'b0;
      tag_q        <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      mem_resp_q   <= 1'b0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
      mem_resp_q   <= mem_resp_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      pmem_addr_q  <= pmem_addr_d;
    end
  end

  // Read misses complete in the same cycle memory answers, so that path is combinational.
  assign bus.mem_resp     = mem_resp_q | ((state_q == st_read) & bus.pmem_resp);
  assign bus.mem_rdata    = (state_q == st_read) ? bus.pmem_rdata : rdata_q;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = pmem_addr_q;
  assign bus.pmem_wdata   = data_q;
endmodule

// File: tb/tb_eviction_write_buffer.sv
// Scoreboard bench: a coherent line-memory model predicts every upstream read,
// and a random-latency memory responder records all downstream traffic.
module tb_eviction_write_buffer;
  localparam int unsigned DD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eviction_write_buffer_if #(.s_line(256)) bus ();

  eviction_write_buffer #(.s_offset(5), .s_line(256), .drain_delay(DD)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { bit is_rd; logic [255:0] data; } exp_t;
  typedef struct { bit wr; int line; } op_t;

  exp_t exp_q[$];
  op_t  log_q[$];
  logic [255:0] pmem_mem [int];
  logic [255:0] ref_mem  [int];
  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  bit pmem_auto = 1'b1;
  bit prev_resp = 1'b0;

  function automatic logic [255:0] pmem_get(input int line);
    if (pmem_mem.exists(line)) return pmem_mem[line];
    return {8{32'(line) ^ 32'hA5A5_0000}};
  endfunction

  // Coherent view: latest acked write, else what memory holds.
  function automatic logic [255:0] ref_get(input int line);
    if (ref_mem.exists(line)) return ref_mem[line];
    return pmem_get(line);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT acks.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.mem_resp) begin
      chk("resp_one_cycle", 256'(prev_resp), 256'(0));
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        if (e.is_rd) chk("read_data", bus.mem_rdata, e.data);
      end
    end
    if (!rst && (bus.pmem_read || bus.pmem_write))
      chk("pmem_rw_exclusive", 256'(bus.pmem_read & bus.pmem_write), 256'(0));
    prev_resp = rst ? 1'b0 : bus.mem_resp;
  end

  // Downstream memory with random latency.
  initial begin
    logic [31:0]  a;
    logic [255:0] wd;
    bit           w;
    int           lat;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_auto && !rst && (bus.pmem_read || bus.pmem_write)) begin
        a = bus.pmem_address; w = bus.pmem_write; wd = bus.pmem_wdata;
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          @(negedge clk);
          chk("pmem_addr_stable", 256'(bus.pmem_address), 256'(a));
          if (w) chk("pmem_wdata_stable", bus.pmem_wdata, wd);
        end
        @(posedge clk); #1;
        bus.pmem_resp = 1'b1;
        if (w) begin
          pmem_mem[int'(a >> 5)] = wd;
          n_wr++;
        end else begin
          bus.pmem_rdata = pmem_get(int'(a >> 5));
          n_rd++;
        end
        log_q.push_back('{w, int'(a >> 5)});
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wd, output int lat);
    exp_t e;
    int   line;
    bit   ok;
    line    = int'(addr >> 5);
    e.is_rd = !wr;
    e.data  = wr ? '0 : ref_get(line);
    if (wr) ref_mem[line] = wd;
    exp_q.push_back(e);
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr; bus.mem_wdata = wd;
    lat = 0; ok = 1'b0;
    while (!ok && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.mem_resp) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL resp_timeout addr=%h actual=no_resp required=resp", addr);
      e = exp_q.pop_back();
    end
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    int q = 0;
    int n = 0;
    while (q < int'(DD) + 4 && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.pmem_read || bus.pmem_write || bus.pmem_resp) q = 0; else q++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL quiet_timeout actual=busy required=idle");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, base, wr0, rd0;
    logic [255:0] d1, d2, d3;
    bit rd, wr;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_mem_resp",   256'(bus.mem_resp),   256'(0));
    chk("reset_pmem_read",  256'(bus.pmem_read),  256'(0));
    chk("reset_pmem_write", 256'(bus.pmem_write), 256'(0));
    @(posedge clk); #1;

    // Buffered write then timed drain.
    d1 = rand_line(); wr0 = n_wr;
    do_req(1'b0, 1'b1, 32'h100, d1, lat);
    chk("write_ack_latency", 256'(lat), 256'(2));
    n = 0;
    while (!bus.pmem_write && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n < int'(DD) || n > int'(DD) + 2) begin
      errors++;
      $display("FAIL drain_delay actual=%0d required=%0d..%0d", n, DD, DD + 2);
    end
    chk("drain_addr", 256'(bus.pmem_address), 256'(32'h100));
    wait_quiet();
    chk("drain_data", pmem_get(8), d1);
    chk("drain_count", 256'(n_wr - wr0), 256'(1));

    // Read hit served from buffer.
    d1 = rand_line(); rd0 = n_rd;
    do_req(1'b0, 1'b1, 32'h100, d1, lat);
    do_req(1'b1, 1'b0, 32'h11C, '0, lat);
    chk("hit_latency", 256'(lat), 256'(2));
    wait_quiet();
    chk("hit_no_pmem_read", 256'(n_rd - rd0), 256'(0));

    // Read miss bypasses pending write-back.
    d1 = rand_line(); base = log_q.size();
    do_req(1'b0, 1'b1, 32'h100, d1, lat);
    do_req(1'b1, 1'b0, 32'h200, '0, lat);
    wait_quiet();
    chk("bypass_op_count", 256'(log_q.size() - base), 256'(2));
    if (log_q.size() >= base + 2) begin
      chk("bypass_first_read", 256'({log_q[base].wr, 32'(log_q[base].line)}), 256'({1'b0, 32'd16}));
      chk("bypass_then_write", 256'({log_q[base+1].wr, 32'(log_q[base+1].line)}), 256'({1'b1, 32'd8}));
    end

    // Conflicting write waits for the drain.
    d1 = rand_line(); d2 = rand_line();
    do_req(1'b0, 1'b1, 32'h100, d1, lat);
    wr0 = n_wr;
    do_req(1'b0, 1'b1, 32'h200, d2, lat);
    chk("conflict_drained_first", 256'(n_wr - wr0), 256'(1));
    wait_quiet();
    chk("conflict_old_line", pmem_get(8), d1);
    chk("conflict_new_line", pmem_get(16), d2);

    // Same-line writes coalesce.
    d1 = rand_line(); d2 = rand_line(); wr0 = n_wr;
    do_req(1'b0, 1'b1, 32'h100, d1, lat);
    do_req(1'b0, 1'b1, 32'h104, d2, lat);
    wait_quiet();
    chk("coalesce_count", 256'(n_wr - wr0), 256'(1));
    chk("coalesce_data", pmem_get(8), d2);

    // Reset during drain drops the buffered line.
    pmem_auto = 1'b0;
    d3 = rand_line();
    do_req(1'b0, 1'b1, 32'h100, d3, lat);
    n = 0;
    while (!bus.pmem_write && n < 50) begin @(negedge clk); n++; end
    chk("rst_drain_started", 256'(bus.pmem_write), 256'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
    chk("rst_mem_resp",   256'(bus.mem_resp),   256'(0));
    ref_mem.delete();
    pmem_auto = 1'b1;
    @(posedge clk); #1;
    rd0 = n_rd;
    do_req(1'b1, 1'b0, 32'h100, '0, lat);
    chk("rst_read_goes_pmem", 256'(n_rd - rd0), 256'(1));
    wait_quiet();

    // Random traffic over a few lines.
    for (int i = 0; i < 250; i++) begin
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 7) == 0);
      do_req(rd, wr, {27'($urandom_range(0, 5)), 5'($urandom_range(0, 31))}, rand_line(), lat);
      idle($urandom_range(0, 7));
    end
    wait_quiet();
    for (int l = 0; l < 6; l++) chk("final_coherent", pmem_get(l), ref_get(l));
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
